// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32I load/store funct3 size codes
//   - 3-bit FSM state encoding
//   - fault-class codes reported by the alignment checker
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE           = 2'd0,
    FC_BAD_FUNCT3     = 2'd1,
    FC_STORE_UNSIGNED = 2'd2,
    FC_MISALIGNED     = 2'd3
  } fault_class_t;

  // Only the five RV32I size codes are meaningful; 011, 110 and 111 are reserved.
  function automatic logic isLegalFunct3(input logic [2:0] funct3);
    return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
           (funct3 == F3_BU) || (funct3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: bundles the EX request, RAM and WB signals of the load/store unit.
//   slave  : the LSU's view (consumes EX/RAM/WB inputs, drives the rest)
//   master : the surrounding pipeline / memory view
interface lsu_if;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic        ex_we_i;
  logic [2:0]  ex_funct3_i;
  logic [31:0] ex_addr_i;
  logic [31:0] ex_wdata_i;
  logic [4:0]  ex_rd_i;
  logic        flush_i;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_we_o;
  logic        mem_re_o;
  logic [2:0]  mem_size_o;
  logic [31:0] mem_data_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_rd_o;
  logic        store_done_o;
  logic        misalign_o;
  logic [31:0] fault_addr_o;

  modport slave (
    input  ex_valid_i, ex_we_i, ex_funct3_i, ex_addr_i, ex_wdata_i, ex_rd_i,
           flush_i, mem_data_i, wb_ready_i,
    output ex_ready_o, mem_addr_o, mem_data_o, mem_we_o, mem_re_o, mem_size_o,
           wb_valid_o, wb_data_o, wb_rd_o, store_done_o, misalign_o, fault_addr_o
  );

  modport master (
    output ex_valid_i, ex_we_i, ex_funct3_i, ex_addr_i, ex_wdata_i, ex_rd_i,
           flush_i, mem_data_i, wb_ready_i,
    input  ex_ready_o, mem_addr_o, mem_data_o, mem_we_o, mem_re_o, mem_size_o,
           wb_valid_o, wb_data_o, wb_rd_o, store_done_o, misalign_o, fault_addr_o
  );
endinterface

// File: rtl/lsu_align_chk.sv
// lsu_align_chk: combinational fault classifier for an incoming request.
//   i_funct3  : RV32I size code of the request
//   i_addrLsb : low two bits of the effective address
//   i_we      : 1 = store
//   o_class   : FC_NONE for a legal request, otherwise the reason it faults
module lsu_align_chk
  import lsu_pkg::*;
(
  input  logic [2:0]   i_funct3,
  input  logic [1:0]   i_addrLsb,
  input  logic         i_we,
  output fault_class_t o_class
);

  // Checks are ordered so that a reserved code is reported as such even when
  // its address would also look misaligned.
  always_comb begin
    o_class = FC_NONE;
    if (!isLegalFunct3(i_funct3)) begin
      o_class = FC_BAD_FUNCT3;
    end else if (i_we && i_funct3[2]) begin
      o_class = FC_STORE_UNSIGNED;
    end else if ((i_funct3 == F3_H || i_funct3 == F3_HU) && i_addrLsb[0]) begin
      o_class = FC_MISALIGNED;
    end else if (i_funct3 == F3_W && i_addrLsb != 2'b00) begin
      o_class = FC_MISALIGNED;
    end
  end

endmodule

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit between EX, a synchronous RAM and WB.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : lsu_if.slave
//     ex_*   : request handshake (valid/ready) with store/load attributes
//     flush_i: kills an in-flight load or an incoming request
//     mem_*  : RAM access, driven only in ISSUE; read data returns one cycle later
//     wb_*   : load result handshake (valid held until ready)
//     store_done_o / misalign_o : one-cycle event pulses
//     fault_addr_o : address of the most recent faulting request
// Data passes through unshifted and unextended; the RAM handles lanes and sign.
module lsu
  import lsu_pkg::*;
(
  input logic  clk,
  input logic  rst,
  lsu_if.slave bus
);

  state_t       r_state;
  logic [31:0]  r_addr;
  logic [31:0]  r_wdata;
  logic         r_we;
  logic [2:0]   r_funct3;
  logic [4:0]   r_rd;
  logic [31:0]  r_wbData;
  logic [31:0]  r_faultAddr;

  logic         w_accept;
  logic         w_fault;
  logic         w_issue;
  fault_class_t w_faultClass;

  lsu_align_chk u_align_chk (
    .i_funct3  (bus.ex_funct3_i),
    .i_addrLsb (bus.ex_addr_i[1:0]),
    .i_we      (bus.ex_we_i),
    .o_class   (w_faultClass)
  );

  assign w_fault  = (w_faultClass != FC_NONE);
  assign w_accept = bus.ex_valid_i && (r_state == S_IDLE) && !bus.flush_i;
  assign w_issue  = (r_state == S_ISSUE);

  // Ready is masked by rst so it reads 0 while reset is held.
  assign bus.ex_ready_o   = (r_state == S_IDLE) && !rst;

  // The RAM bus is zero outside ISSUE so idle cycles never look like accesses.
  assign bus.mem_addr_o   = w_issue ? r_addr   : '0;
  assign bus.mem_data_o   = w_issue ? r_wdata  : '0;
  assign bus.mem_size_o   = w_issue ? r_funct3 : '0;
  assign bus.mem_we_o     = w_issue && r_we;
  assign bus.mem_re_o     = w_issue && !r_we;
  assign bus.store_done_o = w_issue && r_we;

  assign bus.wb_valid_o   = (r_state == S_RESP);
  assign bus.wb_data_o    = r_wbData;
  assign bus.wb_rd_o      = r_rd;
  assign bus.misalign_o   = (r_state == S_FAULT);
  assign bus.fault_addr_o = r_faultAddr;

  // A store is committed once it reaches ISSUE, so flush only cuts loads short.
  // FAULT always runs its single cycle so the pulse is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_funct3    <= '0;
      r_rd        <= '0;
      r_wbData    <= '0;
      r_faultAddr <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr   <= bus.ex_addr_i;
            r_wdata  <= bus.ex_wdata_i;
            r_we     <= bus.ex_we_i;
            r_funct3 <= bus.ex_funct3_i;
            r_rd     <= bus.ex_rd_i;
            if (w_fault) begin
              r_faultAddr <= bus.ex_addr_i;
              r_state     <= S_FAULT;
            end else begin
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (r_we || bus.flush_i) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.flush_i) begin
            r_state <= S_IDLE;
          end else begin
            r_wbData <= bus.mem_data_i;
            r_state  <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.flush_i || bus.wb_ready_i) begin
            r_state <= S_IDLE;
          end
        end
        S_FAULT: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed-vector bench for the load/store unit with a byte-addressed
// RAM model that performs lane selection and sign/zero extension.
module tb_lsu;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lsu_if bus ();

  lsu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        expFault;
    logic [31:0] expData;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  int nVectors     = 0;
  int nMiscompares = 0;

  logic [7:0]  ram [0:1023];
  logic [31:0] ramRdata = '0;
  assign bus.mem_data_i = ramRdata;

  function automatic logic [31:0] ramRead(input logic [2:0] f3, input logic [31:0] a);
    logic [7:0] b0, b1, b2, b3;
    b0 = ram[a[9:0]];
    b1 = ram[a[9:0] + 10'd1];
    b2 = ram[a[9:0] + 10'd2];
    b3 = ram[a[9:0] + 10'd3];
    case (f3)
      F3_B:    return {{24{b0[7]}}, b0};
      F3_H:    return {{16{b1[7]}}, b1, b0};
      F3_W:    return {b3, b2, b1, b0};
      F3_BU:   return {24'h0, b0};
      F3_HU:   return {16'h0, b1, b0};
      default: return 32'h0;
    endcase
  endfunction

  // Synchronous RAM: writes on the sampling edge, read data valid the next cycle.
  always @(posedge clk) begin
    if (bus.mem_we_o) begin
      ram[bus.mem_addr_o[9:0]] <= bus.mem_data_o[7:0];
      if (bus.mem_size_o[1:0] != 2'b00) ram[bus.mem_addr_o[9:0] + 10'd1] <= bus.mem_data_o[15:8];
      if (bus.mem_size_o[1:0] == 2'b10) begin
        ram[bus.mem_addr_o[9:0] + 10'd2] <= bus.mem_data_o[23:16];
        ram[bus.mem_addr_o[9:0] + 10'd3] <= bus.mem_data_o[31:24];
      end
    end
    if (bus.mem_re_o) ramRdata <= ramRead(bus.mem_size_o, bus.mem_addr_o);
  end

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [4:0] rd,
                              input logic expFault, input logic [31:0] expData);
    vec_t v;
    v.we = we; v.funct3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd;
    v.expFault = expFault; v.expData = expData;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for ready, presents one request for one edge, returns #1 after the accept edge.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [4:0] rd);
    int guard;
    guard = 0;
    while (!bus.ex_ready_o && guard < 20) begin
      tick();
      guard++;
    end
    if (!bus.ex_ready_o) checkOutput("ready_timeout", {31'h0, bus.ex_ready_o}, 32'd1);
    bus.ex_valid_i  = 1'b1;
    bus.ex_we_i     = we;
    bus.ex_funct3_i = f3;
    bus.ex_addr_i   = addr;
    bus.ex_wdata_i  = wdata;
    bus.ex_rd_i     = rd;
    tick();
    bus.ex_valid_i  = 1'b0;
  endtask

  task automatic runVector(input vec_t v, input int idx);
    applyStimulus(v.we, v.funct3, v.addr, v.wdata, v.rd);
    if (v.expFault) begin
      checkOutput($sformatf("v%0d_misalign", idx), {31'h0, bus.misalign_o}, 32'd1);
      checkOutput($sformatf("v%0d_fault_addr", idx), bus.fault_addr_o, v.addr);
      checkOutput($sformatf("v%0d_fault_no_mem", idx), {30'h0, bus.mem_re_o, bus.mem_we_o}, 32'd0);
      tick();
      checkOutput($sformatf("v%0d_misalign_end", idx), {31'h0, bus.misalign_o}, 32'd0);
      checkOutput($sformatf("v%0d_fault_ready", idx), {31'h0, bus.ex_ready_o}, 32'd1);
      checkOutput($sformatf("v%0d_fault_addr_hold", idx), bus.fault_addr_o, v.addr);
    end else if (v.we) begin
      checkOutput($sformatf("v%0d_mem_we", idx), {31'h0, bus.mem_we_o}, 32'd1);
      checkOutput($sformatf("v%0d_mem_re", idx), {31'h0, bus.mem_re_o}, 32'd0);
      checkOutput($sformatf("v%0d_mem_addr", idx), bus.mem_addr_o, v.addr);
      checkOutput($sformatf("v%0d_mem_size", idx), {29'h0, bus.mem_size_o}, {29'h0, v.funct3});
      checkOutput($sformatf("v%0d_mem_data", idx), bus.mem_data_o, v.wdata);
      checkOutput($sformatf("v%0d_store_done", idx), {31'h0, bus.store_done_o}, 32'd1);
      tick();
      checkOutput($sformatf("v%0d_st_ready", idx), {31'h0, bus.ex_ready_o}, 32'd1);
      checkOutput($sformatf("v%0d_st_done_end", idx), {31'h0, bus.store_done_o}, 32'd0);
    end else begin
      checkOutput($sformatf("v%0d_mem_re", idx), {31'h0, bus.mem_re_o}, 32'd1);
      checkOutput($sformatf("v%0d_mem_we", idx), {31'h0, bus.mem_we_o}, 32'd0);
      checkOutput($sformatf("v%0d_mem_addr", idx), bus.mem_addr_o, v.addr);
      checkOutput($sformatf("v%0d_mem_size", idx), {29'h0, bus.mem_size_o}, {29'h0, v.funct3});
      tick();
      checkOutput($sformatf("v%0d_wait_valid", idx), {31'h0, bus.wb_valid_o}, 32'd0);
      checkOutput($sformatf("v%0d_wait_bus", idx), {30'h0, bus.mem_re_o, bus.mem_we_o}, 32'd0);
      tick();
      checkOutput($sformatf("v%0d_wb_valid", idx), {31'h0, bus.wb_valid_o}, 32'd1);
      checkOutput($sformatf("v%0d_wb_data", idx), bus.wb_data_o, v.expData);
      checkOutput($sformatf("v%0d_wb_rd", idx), {27'h0, bus.wb_rd_o}, {27'h0, v.rd});
      tick();
      checkOutput($sformatf("v%0d_ld_valid_end", idx), {31'h0, bus.wb_valid_o}, 32'd0);
      checkOutput($sformatf("v%0d_ld_ready", idx), {31'h0, bus.ex_ready_o}, 32'd1);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ex_ready"}, {31'h0, bus.ex_ready_o}, 32'd0);
    checkOutput({tag, "_mem_bus"}, {27'h0, bus.mem_we_o, bus.mem_re_o, bus.mem_size_o}, 32'd0);
    checkOutput({tag, "_mem_addr"}, bus.mem_addr_o, 32'd0);
    checkOutput({tag, "_pulses"}, {29'h0, bus.wb_valid_o, bus.store_done_o, bus.misalign_o}, 32'd0);
    checkOutput({tag, "_wb_data"}, bus.wb_data_o, 32'd0);
    checkOutput({tag, "_wb_rd"}, {27'h0, bus.wb_rd_o}, 32'd0);
    checkOutput({tag, "_fault_addr"}, bus.fault_addr_o, 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    foreach (ram[i]) ram[i] = 8'h00;
    bus.ex_valid_i = 1'b0; bus.ex_we_i = 1'b0; bus.ex_funct3_i = '0;
    bus.ex_addr_i = '0; bus.ex_wdata_i = '0; bus.ex_rd_i = '0;
    bus.flush_i = 1'b0; bus.wb_ready_i = 1'b1;

    vecs[0]  = mk(1'b1, F3_W,   32'h100, 32'hDEADBEEF, 5'd0,  1'b0, 32'h0);
    vecs[1]  = mk(1'b0, F3_W,   32'h100, 32'h0,        5'd5,  1'b0, 32'hDEADBEEF);
    vecs[2]  = mk(1'b1, F3_B,   32'h101, 32'h00000080, 5'd0,  1'b0, 32'h0);
    vecs[3]  = mk(1'b0, F3_B,   32'h101, 32'h0,        5'd6,  1'b0, 32'hFFFFFF80);
    vecs[4]  = mk(1'b0, F3_BU,  32'h101, 32'h0,        5'd7,  1'b0, 32'h00000080);
    vecs[5]  = mk(1'b0, F3_W,   32'h100, 32'h0,        5'd8,  1'b0, 32'hDEAD80EF);
    vecs[6]  = mk(1'b1, F3_H,   32'h202, 32'h1234F00D, 5'd0,  1'b0, 32'h0);
    vecs[7]  = mk(1'b0, F3_H,   32'h202, 32'h0,        5'd9,  1'b0, 32'hFFFFF00D);
    vecs[8]  = mk(1'b0, F3_HU,  32'h202, 32'h0,        5'd10, 1'b0, 32'h0000F00D);
    vecs[9]  = mk(1'b0, F3_B,   32'h203, 32'h0,        5'd11, 1'b0, 32'hFFFFFFF0);
    vecs[10] = mk(1'b0, F3_W,   32'h102, 32'h0,        5'd1,  1'b1, 32'h0);
    vecs[11] = mk(1'b0, F3_H,   32'h103, 32'h0,        5'd1,  1'b1, 32'h0);
    vecs[12] = mk(1'b0, 3'b011, 32'h100, 32'h0,        5'd1,  1'b1, 32'h0);
    vecs[13] = mk(1'b1, F3_BU,  32'h300, 32'h55,       5'd0,  1'b1, 32'h0);
    vecs[14] = mk(1'b0, 3'b110, 32'h104, 32'h0,        5'd1,  1'b1, 32'h0);
    vecs[15] = mk(1'b1, F3_W,   32'h301, 32'h12345678, 5'd0,  1'b1, 32'h0);
    vecs[16] = mk(1'b0, F3_HU,  32'h201, 32'h0,        5'd1,  1'b1, 32'h0);
    vecs[17] = mk(1'b0, F3_BU,  32'h203, 32'h0,        5'd31, 1'b0, 32'h000000F0);

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    checkAllZero("reset");
    rst = 1'b0;
    #1;
    checkOutput("reset_release_ready", {31'h0, bus.ex_ready_o}, 32'd1);

    for (int i = 0; i < NVEC; i++) runVector(vecs[i], i);

    // Result held under WB backpressure
    bus.wb_ready_i = 1'b0;
    applyStimulus(1'b0, F3_W, 32'h200, 32'h0, 5'd13);
    checkOutput("bp_issue_ready", {31'h0, bus.ex_ready_o}, 32'd0);
    tick();
    checkOutput("bp_wait_ready", {31'h0, bus.ex_ready_o}, 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp_valid_%0d", i), {31'h0, bus.wb_valid_o}, 32'd1);
      checkOutput($sformatf("bp_data_%0d", i), bus.wb_data_o, 32'hF00D0000);
      checkOutput($sformatf("bp_rd_%0d", i), {27'h0, bus.wb_rd_o}, 32'd13);
      checkOutput($sformatf("bp_ready_%0d", i), {31'h0, bus.ex_ready_o}, 32'd0);
      if (i < 4) tick();
    end
    bus.wb_ready_i = 1'b1;
    tick();
    checkOutput("bp_idle_ready", {31'h0, bus.ex_ready_o}, 32'd1);
    checkOutput("bp_idle_valid", {31'h0, bus.wb_valid_o}, 32'd0);

    // Flush while the load waits for RAM data
    applyStimulus(1'b0, F3_W, 32'h100, 32'h0, 5'd3);
    tick();
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    checkOutput("flw_valid", {31'h0, bus.wb_valid_o}, 32'd0);
    checkOutput("flw_ready", {31'h0, bus.ex_ready_o}, 32'd1);
    tick();
    checkOutput("flw_valid_late", {31'h0, bus.wb_valid_o}, 32'd0);

    // Flush in ISSUE of a load
    applyStimulus(1'b0, F3_W, 32'h100, 32'h0, 5'd3);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    checkOutput("fli_ready", {31'h0, bus.ex_ready_o}, 32'd1);
    tick();
    checkOutput("fli_valid", {31'h0, bus.wb_valid_o}, 32'd0);

    // Flush in ISSUE of a store: write still lands
    applyStimulus(1'b1, F3_W, 32'h400, 32'hCAFEF00D, 5'd0);
    bus.flush_i = 1'b1;
    checkOutput("fls_mem_we", {31'h0, bus.mem_we_o}, 32'd1);
    checkOutput("fls_store_done", {31'h0, bus.store_done_o}, 32'd1);
    tick();
    bus.flush_i = 1'b0;
    checkOutput("fls_ready", {31'h0, bus.ex_ready_o}, 32'd1);
    runVector(mk(1'b0, F3_W, 32'h400, 32'h0, 5'd12, 1'b0, 32'hCAFEF00D), 100);

    // Flush coinciding with a request in IDLE drops it
    bus.ex_valid_i = 1'b1; bus.ex_we_i = 1'b1; bus.ex_funct3_i = F3_W;
    bus.ex_addr_i = 32'h100; bus.ex_wdata_i = 32'h11111111; bus.flush_i = 1'b1;
    tick();
    bus.ex_valid_i = 1'b0; bus.flush_i = 1'b0;
    checkOutput("fld_mem_we", {31'h0, bus.mem_we_o}, 32'd0);
    checkOutput("fld_ready", {31'h0, bus.ex_ready_o}, 32'd1);
    runVector(mk(1'b0, F3_W, 32'h100, 32'h0, 5'd4, 1'b0, 32'hDEAD80EF), 101);

    // Flush during FAULT has no effect on the pulse
    applyStimulus(1'b0, F3_W, 32'h106, 32'h0, 5'd2);
    bus.flush_i = 1'b1;
    checkOutput("flf_misalign", {31'h0, bus.misalign_o}, 32'd1);
    checkOutput("flf_fault_addr", bus.fault_addr_o, 32'h106);
    tick();
    bus.flush_i = 1'b0;
    checkOutput("flf_misalign_end", {31'h0, bus.misalign_o}, 32'd0);
    checkOutput("flf_ready", {31'h0, bus.ex_ready_o}, 32'd1);

    // Reset pulsed during WAIT, then a normal load
    applyStimulus(1'b0, F3_W, 32'h100, 32'h0, 5'd14);
    tick();
    #2;
    rst = 1'b1;
    #1;
    checkAllZero("rstw");
    tick();
    checkOutput("rstw_valid_held", {31'h0, bus.wb_valid_o}, 32'd0);
    #2;
    rst = 1'b0;
    tick();
    runVector(mk(1'b0, F3_W, 32'h100, 32'h0, 5'd14, 1'b0, 32'hDEAD80EF), 102);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have the following ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_valid_i  in  1  request from EX.
- ex_ready_o  out  1  LSU can accept a request.
- ex_we_i  in  1  1=store, 0=load.
- ex_funct3_i  in  3  RV32I funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- ex_addr_i  in  32  effective byte address.
- ex_wdata_i  in  32  store data, unshifted.
- ex_rd_i  in  5  load destination register.
- flush_i  in  1  pipeline flush.
- mem_addr_o  out  32  RAM byte address.
- mem_data_o  out  32  RAM write data.
- mem_we_o  out  1  RAM write enable.
- mem_re_o  out  1  RAM read enable.
- mem_size_o  out  3  RAM size code (equals funct3).
- mem_data_i  in  32  RAM read data, valid the cycle after the RAM samples mem_re_o.
- wb_valid_o  out  1  load result valid.
- wb_ready_i  in  1  WB accepts the result.
- wb_data_o  out  32  load result.
- wb_rd_o  out  5  load destination register.
- store_done_o  out  1  one-cycle pulse when a store is issued.
- misalign_o  out  1  one-cycle fault pulse.
- fault_addr_o  out  32  faulting address; held until the next fault.

Function
REQ-002 SHALL implement the FSM states IDLE, ISSUE, WAIT, RESP, FAULT.
REQ-003 SHALL drive ex_ready_o = (state==IDLE); a request is accepted on a rising edge when ex_valid_i && ex_ready_o && !flush_i.
REQ-004 SHALL latch addr, wdata, we, funct3 and rd into request registers on acceptance.
REQ-005 SHALL classify a request as a fault when any of the following holds: funct3 is 011, 110 or 111; a store has funct3[2]=1; a halfword access has addr[0]=1; a word access has addr[1:0]!=0.
REQ-006 SHALL go IDLE->FAULT on accepting a faulting request; in FAULT, assert misalign_o for exactly one cycle, load fault_addr_o, issue no memory access, then return to IDLE.
REQ-007 SHALL go IDLE->ISSUE on accepting a legal request.
REQ-008 SHALL, in ISSUE, drive mem_addr_o, mem_data_o and mem_size_o from the request registers, and assert mem_we_o=we and mem_re_o=!we.
REQ-009 SHALL, in ISSUE with a store, pulse store_done_o and go ISSUE->IDLE; a store therefore occupies 1 cycle after acceptance.
REQ-010 SHALL, in ISSUE with a load, go ISSUE->WAIT.
REQ-011 SHALL, in WAIT, capture mem_data_i into wb_data_o and go WAIT->RESP.
REQ-012 SHALL, in RESP, hold wb_valid_o=1 with stable wb_data_o and wb_rd_o until wb_ready_i=1, then return to IDLE.
REQ-013 SHALL give load latency of 2 edges from the accept edge to wb_valid_o high; back-to-back throughput is 1 load per 4 cycles when wb_ready_i is tied high.
REQ-014 SHALL, outside ISSUE, drive mem_we_o=0, mem_re_o=0, mem_addr_o=0, mem_data_o=0 and mem_size_o=0.
REQ-015 SHALL apply flush_i in ISSUE (load), WAIT or RESP by returning to IDLE on the next edge with no wb_valid_o.
REQ-016 SHALL NOT cancel a store in ISSUE via flush_i; the write still occurs.
REQ-017 SHALL drop a request when flush_i and ex_valid_i coincide in IDLE.
REQ-018 SHALL treat flush_i in FAULT as having no effect; the fault pulse still appears.
REQ-019 SHALL perform no sign or zero extension and no lane shifting; the RAM performs both.

Reset
REQ-020 SHALL, while rst=1, immediately force state=IDLE and drive all outputs to 0 (ex_ready_o returns to 1 after release), with fault_addr_o=0.
REQ-021 SHALL, on reset asserted mid-operation, produce no write pulse, no wb_valid_o and no misalign_o.

Structure
REQ-022 SHALL define the funct3 codes, the FSM state encoding (3 bits) and the fault-class constants in the shared package lsu_pkg.
REQ-023 SHALL place the fault-classification logic (REQ-005) in the combinational sub-module lsu_align_chk, instantiated once.

Verification
REQ-024 SHALL cover: sw addr 0x100, data 0xDEADBEEF, accepted -> next cycle mem_we_o=1, mem_size_o=010, mem_addr_o=0x100, store_done_o=1; ex_ready_o=1 the cycle after.
REQ-025 SHALL cover: lb addr 0x101 after sb 0x80 at 0x101 -> wb_valid_o 2 edges after accept, wb_data_o=0xFFFFFF80; lbu same address -> 0x00000080.
REQ-026 SHALL cover: lw addr 0x102 -> misalign_o one cycle, fault_addr_o=0x102, mem_re_o never asserted; lh 0x103 and funct3=011 also fault.
REQ-027 SHALL cover: load with wb_ready_i=0 for 5 cycles -> wb_valid_o and wb_data_o stable for 5 cycles, ex_ready_o=0 throughout, IDLE one cycle after wb_ready_i rises.
REQ-028 SHALL cover: flush_i in WAIT of a load -> no wb_valid_o; flush_i in ISSUE of sw -> RAM word still updated.
REQ-029 SHALL cover: rst pulsed during WAIT -> all outputs 0 immediately, next load after release completes normally.
